// File: rtl/regfile.sv
// Architectural integer register file: NREG x 32-bit, index 0 hardwired to zero.
// Two combinational read ports with write-first forwarding of the value being
// committed from MEM/WB in the same cycle.
module regfile #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          wb_we,
    input  logic [31:0]   wb_w_addr,
    input  logic [31:0]   wb_w_data,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [31:0]   rdata1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [31:0]   rdata2
);

    logic [31:0]   regs_q [NREG];
    logic [AW-1:0] waddr;
    logic          wr_en;
    logic          byp_en;

    // Upper write-index bits are architecturally ignored.
    logic unused_waddr_hi;
    assign unused_waddr_hi = ^wb_w_addr[31:AW];

    assign waddr  = wb_w_addr[AW-1:0];
    assign wr_en  = rdy_in && wb_we && (waddr != '0);
    // Forwarding is suppressed while in reset so reads see the cleared state.
    assign byp_en = !rst_in && rdy_in && wb_we;

    // Storage update: asynchronous clear, single write port, x0 never written.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr] <= wb_w_data;
        end
    end

    function automatic logic [31:0] read_port(input logic re, input logic [AW-1:0] raddr);
        logic [31:0] val;
        val = '0;
        if (!re || raddr == '0) begin
            val = '0;
        end else if (byp_en && raddr == waddr) begin
            val = wb_w_data;
        end else begin
            val = regs_q[raddr];
        end
        return val;
    endfunction

    // Read ports: enable, x0, bypass, then stored value, in priority order.
    always_comb begin
        rdata1 = read_port(re1, raddr1);
        rdata2 = read_port(re2, raddr2);
    end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile.
module tb_regfile;

    localparam int unsigned AW = 5;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b1;
    logic          wb_we = 1'b0;
    logic [31:0]   wb_w_addr = '0;
    logic [31:0]   wb_w_data = '0;
    logic          re1 = 1'b1;
    logic [AW-1:0] raddr1 = '0;
    logic [31:0]   rdata1;
    logic          re2 = 1'b1;
    logic [AW-1:0] raddr2 = '0;
    logic [31:0]   rdata2;

    int n_vec = 0;
    int n_err = 0;

    regfile #(.NREG(32), .AW(AW)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .wb_we     (wb_we),
        .wb_w_addr (wb_w_addr),
        .wb_w_data (wb_w_data),
        .re1       (re1),
        .raddr1    (raddr1),
        .rdata1    (rdata1),
        .re2       (re2),
        .raddr2    (raddr2),
        .rdata2    (rdata2)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        wb_we = 1'b1;
        wb_w_addr = addr;
        wb_w_data = data;
    endtask

    task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        raddr1 = a1;
        raddr2 = a2;
        #1;
    endtask

    initial begin
        #2 rst_in = 1'b1;
        #1;
        // All indices read zero in reset, on both ports.
        for (int i = 0; i < 32; i++) begin
            rd(AW'(i), AW'(31 - i));
            check($sformatf("rst_p1_%0d", i), rdata1, 32'h0);
            check($sformatf("rst_p2_%0d", 31 - i), rdata2, 32'h0);
        end
        // Bypass is suppressed during reset.
        wr(32'd4, 32'h0BAD_0BAD);
        rd(5'd4, 5'd4);
        check("rst_bypass", rdata1, 32'h0);
        tick();
        check("rst_nowrite", rdata2, 32'h0);
        rst_in = 1'b0;
        wb_we = 1'b0;
        rd(5'd4, 5'd4);
        check("post_rst_r4", rdata1, 32'h0);

        // Write to x0 is dropped and x0 never forwards.
        wr(32'd0, 32'hDEAD_BEEF);
        rd(5'd0, 5'd0);
        check("x0_same", rdata1, 32'h0);
        tick();
        wb_we = 1'b0;
        rd(5'd0, 5'd0);
        check("x0_after", rdata2, 32'h0);

        // Write then read next cycle.
        wr(32'd5, 32'h1234_5678);
        tick();
        wb_we = 1'b0;
        rd(5'd5, 5'd0);
        check("wr_rd5", rdata1, 32'h1234_5678);

        // Bypass on both ports over an old value.
        wr(32'd7, 32'h0000_0001);
        tick();
        wb_we = 1'b0;
        rd(5'd7, 5'd7);
        check("r7_old", rdata1, 32'h1);
        wr(32'd7, 32'hCAFE_F00D);
        rd(5'd7, 5'd7);
        check("byp_p1", rdata1, 32'hCAFE_F00D);
        check("byp_p2", rdata2, 32'hCAFE_F00D);
        tick();
        wb_we = 1'b0;
        rd(5'd7, 5'd7);
        check("byp_p1_later", rdata1, 32'hCAFE_F00D);
        check("byp_p2_later", rdata2, 32'hCAFE_F00D);

        // rdy_in low freezes state and disables bypass.
        wr(32'd9, 32'h0000_9999);
        tick();
        rdy_in = 1'b0;
        wr(32'd9, 32'hAAAA_0000);
        rd(5'd9, 5'd9);
        check("rdy0_same", rdata1, 32'h0000_9999);
        tick();
        check("rdy0_next", rdata1, 32'h0000_9999);
        rdy_in = 1'b1;
        wb_we = 1'b0;
        rd(5'd9, 5'd9);
        check("rdy1_stored", rdata2, 32'h0000_9999);

        // Read enable low forces zero; other port unaffected.
        re1 = 1'b0;
        rd(5'd9, 5'd9);
        check("re1_off", rdata1, 32'h0);
        check("re2_on", rdata2, 32'h0000_9999);
        re1 = 1'b1;

        // Upper write-index bits ignored: 0xFFFFFFE3 -> index 3.
        wr(32'hFFFF_FFE3, 32'h0000_0055);
        rd(5'd3, 5'd3);
        check("trunc_byp", rdata1, 32'h55);
        tick();
        wb_we = 1'b0;
        rd(5'd3, 5'd3);
        check("trunc_r3", rdata2, 32'h55);

        // Back-to-back writes to one index: last wins.
        wr(32'd10, 32'h11);
        tick();
        wr(32'd10, 32'h22);
        rd(5'd10, 5'd10);
        check("b2b_same", rdata1, 32'h22);
        tick();
        wb_we = 1'b0;
        rd(5'd10, 5'd10);
        check("b2b_after", rdata2, 32'h22);

        // Flushed bundle neither writes nor forwards.
        wb_we = 1'b0;
        wb_w_addr = 32'd5;
        wb_w_data = 32'hFFFF_FFFF;
        rd(5'd5, 5'd5);
        check("flush_nobyp", rdata1, 32'h1234_5678);
        tick();
        rd(5'd5, 5'd5);
        check("flush_nowr", rdata2, 32'h1234_5678);

        // Reset asserted during a write discards it and clears everything.
        wr(32'd12, 32'h77);
        #1 rst_in = 1'b1;
        rd(5'd12, 5'd5);
        check("mid_rst_r12", rdata1, 32'h0);
        check("mid_rst_r5", rdata2, 32'h0);
        tick();
        rst_in = 1'b0;
        wb_we = 1'b0;
        rd(5'd12, 5'd7);
        check("post_rst_r12", rdata1, 32'h0);
        check("post_rst_r7", rdata2, 32'h0);
        rd(5'd3, 5'd10);
        check("post_rst_r3", rdata1, 32'h0);
        check("post_rst_r10", rdata2, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
